seq_controle_acc: RTL and testbench
===================================

// Module: seq_controle_acc
// PURPOSE
//  Multi-cycle control unit for the 4-bit datapath: RegX, RegY (accumulator), RegZ (display) and ULA.
//  Accepts one opcode per start/busy handshake and drives the tx/ty/tz register commands and ula_sel.
//  Its sequence writes the ULA result into RegY, optionally shifts RegY right N times, then copies Y to Z.
//  Sits between the top-level input decoder (keys/switches) and the register/ULA instances.
// PARAMETERS
//  CMDW   4  width of register command buses tx/ty/tz and of ula_sel
//  CNTW   3  width of shift-count operand (max 2^CNTW-1 shifts)
// PORTS
//  clock    in   1     system clock, all state updates on posedge
//  reset    in   1     asynchronous, active-low reset (0 = reset)
//  start    in   1     request; sampled only in IDLE
//  opcode   in   4     operation, sampled with start
//  count    in   CNTW  shift count for SHR, sampled with start
//  tx       out  CMDW  RegX command
//  ty       out  CMDW  RegY command
//  tz       out  CMDW  RegZ command
//  ula_sel  out  CMDW  ULA operation select
//  busy     out  1     1 whenever state != IDLE
//  done     out  1     1-cycle pulse in DONE
//  err      out  1     sticky illegal-opcode flag, cleared by next accepted start
// BEHAVIOUR
//  Register cmds: CLEAR=0 LOAD=1 HOLD=2 SHIFTR=3. ULA sel: ADD=0 SUB=1 AND=2 OR=3 PASSY=4.
//  Opcodes: 0 NOP, 1 CLR, 2 LDX, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 SHR, 8 MOVYZ, 9-15 illegal.
//  Reset (async, reset=0): state=IDLE, cnt=0, tx=ty=tz=HOLD, ula_sel=ADD, busy=0, done=0, err=0.
//   Reset mid-sequence aborts immediately; no further commands issued; registers keep their contents.
//  Outputs are Moore-decoded from state + latched opcode; every command not listed below is HOLD.
//  Accept: state==IDLE && start at posedge -> latch opcode,count; clear err; go to EXEC.
//   start while busy is ignored (not queued). start held in DONE is NOT accepted until IDLE.
//  States:
//   IDLE : all HOLD, busy=0.
//   EXEC : NOP -> DONE, no command.
//          CLR -> tx=ty=tz=CLEAR, -> DONE.
//          LDX -> tx=LOAD, -> DONE.
//          ADD/SUB/AND/OR -> ula_sel=op, ty=LOAD, -> WRITE.
//          SHR -> no command; cnt<=count; -> SHIFT if count!=0 else WRITE.
//          MOVYZ -> -> WRITE.
//          illegal -> err<=1, -> DONE, no command.
//   SHIFT: ty=SHIFTR; cnt<=cnt-1; stay while cnt>1, -> WRITE when cnt==1.
//          Exactly `count` cycles with ty=SHIFTR; no wrap (cnt never decremented at 0).
//   WRITE: ula_sel=PASSY, tz=LOAD (Z <= Y as updated by prior edge), -> DONE.
//   DONE : done=1, busy=1, all HOLD, -> IDLE.
//  Latency, accept edge to done pulse: NOP/CLR/LDX/illegal 2 cycles (EXEC,DONE);
//   ALU ops and MOVYZ 3 (EXEC,WRITE,DONE); SHR 3+count.
//  Back-to-back: next start accepted in cycle after DONE (IDLE); min issue interval = latency+1.
//  opcode/count changing after accept have no effect on the running sequence.
//  Only one of tx/ty/tz is non-HOLD per cycle except CLR (all three CLEAR together).
// TESTING
//  1 Reset low 3 cycles, release -> tx=ty=tz=2, ula_sel=0, busy=0, done=0, err=0.
//  2 start,op=3(ADD) -> EXEC ula_sel=0 ty=1; WRITE ula_sel=4 tz=1; done 1 cycle; busy 3 cycles.
//  3 op=7,count=3 -> ty=3 on exactly 3 consecutive cycles, then tz=1, done; Y=4'b1000 ends 4'b0001, Z=1.
//  4 op=7,count=0 -> no ty=3 cycle; WRITE then done (latency 3); 
//    op=2 then op=1 back-to-back -> tx=1 one cycle, later tx=ty=tz=0 one cycle.
//  5 op=12 -> err=1 stays after done; start op=0 -> err clears on accept; start pulsed during busy ignored.
//  6 op=7,count=5, reset low during 2nd shift -> commands HOLD same cycle, busy=0; after release IDLE, no shifts.

Source files
------------

// File: rtl/seq_controle_acc_if.sv
// Handshake and command bundle between the input decoder, the control unit
// and the register/ULA instances.
interface seq_controle_acc_if #(
  parameter int CMDW = 4,
  parameter int CNTW = 3
);
  logic            start;
  logic [3:0]      opcode;
  logic [CNTW-1:0] count;
  logic [CMDW-1:0] tx;
  logic [CMDW-1:0] ty;
  logic [CMDW-1:0] tz;
  logic [CMDW-1:0] ula_sel;
  logic            busy;
  logic            done;
  logic            err;

  // Requester side (decoder / bench)
  modport master (
    output start, opcode, count,
    input  tx, ty, tz, ula_sel, busy, done, err
  );

  // Control unit side
  modport slave (
    input  start, opcode, count,
    output tx, ty, tz, ula_sel, busy, done, err
  );
endinterface

// File: rtl/seq_controle_acc.sv
// Multi-cycle control unit for the 4-bit RegX/RegY/RegZ/ULA datapath.
// One opcode per start/busy handshake; commands are decoded from the next
// state and latched opcode and registered, so they change exactly with the
// state and are glitch-free at the register inputs.
module seq_controle_acc #(
  parameter int CMDW = 4,
  parameter int CNTW = 3
) (
  input  logic               clock,
  input  logic               reset,
  seq_controle_acc_if.slave  bus_if
);

  localparam logic [CMDW-1:0] CMD_CLEAR  = CMDW'(0);
  localparam logic [CMDW-1:0] CMD_LOAD   = CMDW'(1);
  localparam logic [CMDW-1:0] CMD_HOLD   = CMDW'(2);
  localparam logic [CMDW-1:0] CMD_SHIFTR = CMDW'(3);

  localparam logic [CMDW-1:0] ULA_ADD    = CMDW'(0);
  localparam logic [CMDW-1:0] ULA_SUB    = CMDW'(1);
  localparam logic [CMDW-1:0] ULA_AND    = CMDW'(2);
  localparam logic [CMDW-1:0] ULA_OR     = CMDW'(3);
  localparam logic [CMDW-1:0] ULA_PASSY  = CMDW'(4);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_CLR   = 4'd1;
  localparam logic [3:0] OP_LDX   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_MOVYZ = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_SHIFT = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [CMDW-1:0] tx_q, tx_d;
  logic [CMDW-1:0] ty_q, ty_d;
  logic [CMDW-1:0] tz_q, tz_d;
  logic [CMDW-1:0] sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept_s;

  assign accept_s = (state_q == S_IDLE) && bus_if.start;

  // State, operand latches and registered command outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      count_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tx_q    <= CMD_HOLD;
      ty_q    <= CMD_HOLD;
      tz_q    <= CMD_HOLD;
      sel_q   <= ULA_ADD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      tz_q    <= tz_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state sequencing: accept, opcode dispatch, shift countdown
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d    = bus_if.opcode;
          count_d = bus_if.count;
          err_d   = 1'b0;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_NOP, OP_CLR, OP_LDX:          state_d = S_DONE;
          OP_ADD, OP_SUB, OP_AND, OP_OR:   state_d = S_WRITE;
          OP_MOVYZ:                        state_d = S_WRITE;
          OP_SHR: begin
            cnt_d = count_q;
            if (count_q != '0) begin
              state_d = S_SHIFT;
            end else begin
              state_d = S_WRITE;
            end
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      S_SHIFT: begin
        // Counter never wraps: it is only decremented while non-zero
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (cnt_q > CNTW'(1)) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore command decode of the upcoming state and opcode
  always_comb begin
    tx_d   = CMD_HOLD;
    ty_d   = CMD_HOLD;
    tz_d   = CMD_HOLD;
    sel_d  = ULA_ADD;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    case (state_d)
      S_EXEC: begin
        case (op_d)
          OP_CLR: begin
            tx_d = CMD_CLEAR;
            ty_d = CMD_CLEAR;
            tz_d = CMD_CLEAR;
          end
          OP_LDX: tx_d = CMD_LOAD;
          OP_ADD: begin sel_d = ULA_ADD; ty_d = CMD_LOAD; end
          OP_SUB: begin sel_d = ULA_SUB; ty_d = CMD_LOAD; end
          OP_AND: begin sel_d = ULA_AND; ty_d = CMD_LOAD; end
          OP_OR:  begin sel_d = ULA_OR;  ty_d = CMD_LOAD; end
          default: tx_d = CMD_HOLD;
        endcase
      end
      S_SHIFT: ty_d = CMD_SHIFTR;
      S_WRITE: begin
        sel_d = ULA_PASSY;
        tz_d  = CMD_LOAD;
      end
      default: tx_d = CMD_HOLD;
    endcase
  end

  assign bus_if.tx      = tx_q;
  assign bus_if.ty      = ty_q;
  assign bus_if.tz      = tz_q;
  assign bus_if.ula_sel = sel_q;
  assign bus_if.busy    = busy_q;
  assign bus_if.done    = done_q;
  assign bus_if.err     = err_q;

endmodule

// File: tb/tb_seq_controle_acc.sv
// Bench for seq_controle_acc: a per-cycle schedule model built from the
// opcode table, a small RegX/RegY/RegZ/ULA datapath driven by the DUT
// commands, and directed vectors with hand-computed expectations.
module tb_seq_controle_acc;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  seq_controle_acc_if #(.CMDW(4), .CNTW(3)) bus ();

  seq_controle_acc #(.CMDW(4), .CNTW(3)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_if (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] tx;
    logic [3:0] ty;
    logic [3:0] tz;
    logic [3:0] sel;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t q[$];
  logic err_m = 1'b0;

  function automatic exp_t mk(logic [3:0] tx, logic [3:0] ty, logic [3:0] tz,
                              logic [3:0] sel, logic done, logic err);
    exp_t e;
    e.tx = tx; e.ty = ty; e.tz = tz; e.sel = sel;
    e.busy = 1'b1; e.done = done; e.err = err;
    return e;
  endfunction

  // Expand one accepted opcode into its cycle-by-cycle command schedule
  task automatic model_accept(input logic [3:0] op, input logic [2:0] cnt);
    exp_t ex;
    ex = mk(4'd2, 4'd2, 4'd2, 4'd0, 1'b0, 1'b0);
    if (op == 4'd1) begin ex.tx = 4'd0; ex.ty = 4'd0; ex.tz = 4'd0; end
    if (op == 4'd2) ex.tx = 4'd1;
    if (op >= 4'd3 && op <= 4'd6) begin ex.sel = op - 4'd3; ex.ty = 4'd1; end
    q.push_back(ex);
    if (op == 4'd7)
      for (int i = 0; i < int'(cnt); i++) q.push_back(mk(4'd2, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0));
    if (op >= 4'd3 && op <= 4'd8) q.push_back(mk(4'd2, 4'd2, 4'd1, 4'd4, 1'b0, 1'b0));
    q.push_back(mk(4'd2, 4'd2, 4'd2, 4'd0, 1'b1, (op > 4'd8)));
  endtask

  task automatic model_step();
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (q.size() == 0) err_m = e.err;
    end else if (bus.start) begin
      model_accept(bus.opcode, bus.count);
    end
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    if (q.size() != 0) begin
      e = q[0];
    end else begin
      e = mk(4'd2, 4'd2, 4'd2, 4'd0, 1'b0, err_m);
      e.busy = 1'b0;
    end
    return e;
  endfunction

  // Per-cycle comparison of every output against the schedule model
  always @(negedge clock) begin
    exp_t e_v;
    exp_t a_v;
    e_v = cur_exp();
    a_v = {bus.tx, bus.ty, bus.tz, bus.ula_sel, bus.busy, bus.done, bus.err};
    vectors++;
    if (a_v !== e_v) begin
      miscompares++;
      $display("FAIL cycle_outputs t=%0t got tx=%0d ty=%0d tz=%0d sel=%0d busy=%0b done=%0b err=%0b expected tx=%0d ty=%0d tz=%0d sel=%0d busy=%0b done=%0b err=%0b",
               $time, a_v.tx, a_v.ty, a_v.tz, a_v.sel, a_v.busy, a_v.done, a_v.err,
               e_v.tx, e_v.ty, e_v.tz, e_v.sel, e_v.busy, e_v.done, e_v.err);
    end
  end

  // Small datapath driven by the DUT commands
  logic [3:0] regx = 4'd0, regy = 4'd0, regz = 4'd0;
  logic       pre_en = 1'b0;
  logic [3:0] pre_val = 4'd0;
  logic [3:0] ula;
  always_comb begin
    case (bus.ula_sel)
      4'd0:    ula = regx + regy;
      4'd1:    ula = regx - regy;
      4'd2:    ula = regx & regy;
      4'd3:    ula = regx | regy;
      4'd4:    ula = regy;
      default: ula = 4'd0;
    endcase
  end

  // Register updates on each clock from the commands of the ending cycle
  always @(posedge clock) begin
    case (bus.tx)
      4'd0: regx <= 4'd0;
      4'd1: regx <= 4'd5;
      4'd3: regx <= regx >> 1;
      default: regx <= regx;
    endcase
    if (pre_en) regy <= pre_val;
    else case (bus.ty)
      4'd0: regy <= 4'd0;
      4'd1: regy <= ula;
      4'd3: regy <= regy >> 1;
      default: regy <= regy;
    endcase
    case (bus.tz)
      4'd0: regz <= 4'd0;
      4'd1: regz <= ula;
      4'd3: regz <= regz >> 1;
      default: regz <= regz;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_step();
    #1;
  endtask

  // One handshake; returns latency and command occurrence counts
  task automatic run_op(input logic [3:0] op, input logic [2:0] cnt, input bit start_in_done,
                        output int lat, output int shr, output int txl, output int clr);
    lat = 0; shr = 0; txl = 0; clr = 0;
    bus.start = 1'b1; bus.opcode = op; bus.count = cnt;
    tick();
    bus.start = 1'b0; bus.opcode = ~op; bus.count = ~cnt;
    for (int i = 0; i < 40; i++) begin
      lat++;
      if (bus.ty == 4'd3) shr++;
      if (bus.tx == 4'd1) txl++;
      if (bus.tx == 4'd0 && bus.ty == 4'd0 && bus.tz == 4'd0) clr++;
      if (bus.done) break;
      tick();
    end
    check("done_seen", int'(bus.done), 1);
    if (start_in_done) begin
      bus.start = 1'b1; bus.opcode = op;
      tick();
      check("no_accept_in_done", int'(bus.busy), 0);
      bus.start = 1'b0;
    end else begin
      tick();
    end
  endtask

  int lat, shr, txl, clr;
  logic [3:0] ops [6] = '{4'd0, 4'd4, 4'd5, 4'd6, 4'd8, 4'd15};
  int         lats[6] = '{2, 3, 3, 3, 3, 2};

  initial begin
    bus.start = 1'b0; bus.opcode = 4'd0; bus.count = 3'd0;
    reset = 1'b0;
    q.delete(); err_m = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    // Reset state
    check("rst_tx", int'(bus.tx), 2);
    check("rst_ty", int'(bus.ty), 2);
    check("rst_tz", int'(bus.tz), 2);
    check("rst_sel", int'(bus.ula_sel), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);

    // ADD: three busy cycles
    run_op(4'd3, 3'd0, 1'b0, lat, shr, txl, clr);
    check("add_latency", lat, 3);

    // SHR by 3 on Y=8
    pre_en = 1'b1; pre_val = 4'b1000;
    tick();
    pre_en = 1'b0;
    run_op(4'd7, 3'd3, 1'b0, lat, shr, txl, clr);
    check("shr3_shifts", shr, 3);
    check("shr3_latency", lat, 6);
    check("shr3_regy", int'(regy), 1);
    check("shr3_regz", int'(regz), 1);

    // SHR by 0
    run_op(4'd7, 3'd0, 1'b0, lat, shr, txl, clr);
    check("shr0_shifts", shr, 0);
    check("shr0_latency", lat, 3);

    // LDX then CLR back-to-back; start held during DONE of LDX
    run_op(4'd2, 3'd0, 1'b1, lat, shr, txl, clr);
    check("ldx_txload", txl, 1);
    check("ldx_latency", lat, 2);
    run_op(4'd1, 3'd0, 1'b0, lat, shr, txl, clr);
    check("clr_allclear", clr, 1);
    check("clr_latency", lat, 2);

    // Remaining opcodes
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], 3'd2, 1'b0, lat, shr, txl, clr);
      check($sformatf("latency_op%0d", ops[i]), lat, lats[i]);
    end

    // Illegal opcode: sticky err, cleared by next accept; start while busy ignored
    run_op(4'd12, 3'd0, 1'b0, lat, shr, txl, clr);
    check("ill_latency", lat, 2);
    tick();
    check("ill_err_sticky", int'(bus.err), 1);
    bus.start = 1'b1; bus.opcode = 4'd0;
    tick();
    check("err_clear_on_accept", int'(bus.err), 0);
    bus.opcode = 4'd3;
    tick();
    bus.start = 1'b0;
    check("nop_done", int'(bus.done), 1);
    tick();
    check("busy_start_ignored_a", int'(bus.busy), 0);
    tick();
    check("busy_start_ignored_b", int'(bus.busy), 0);

    // Reset during the second shift of SHR by 5
    bus.start = 1'b1; bus.opcode = 4'd7; bus.count = 3'd5;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("pre_abort_shift", int'(bus.ty), 3);
    #2;
    reset = 1'b0;
    q.delete(); err_m = 1'b0;
    #1;
    check("abort_ty_hold", int'(bus.ty), 2);
    check("abort_busy", int'(bus.busy), 0);
    tick();
    tick();
    reset = 1'b1;
    shr = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.ty == 4'd3) shr++;
    end
    check("abort_no_shifts", shr, 0);
    check("abort_idle", int'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
